freq_stepper: RTL and testbench

- Consumer end of the frequency-optimisation handshake.
- Accepts ready/direction/optimum strobes from the optimiser and steps the converter switching period up or down.
- Generates complementary dead-timed gate drive at the current period.
- Sits between the optimiser and the half-bridge gate drivers. clk 50 MHz; nominal power frequency ~40 kHz, i.e. 1250 clk per period.

---
 rtl/freq_stepper.sv | 76 +++++++
 tb/tb_freq_stepper.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/freq_stepper.sv
// freq_stepper: steps the switching period on optimiser requests and drives dead-timed complementary gates
module freq_stepper #(
  parameter int PERIOD_INIT = 1250,
  parameter int PERIOD_MIN  = 1000,
  parameter int PERIOD_MAX  = 1600,
  parameter int STEP_INIT   = 16,
  parameter int DEAD        = 10,
  parameter int PW          = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          freq_ready,
  input  logic          freq_set_up_down,
  input  logic          freq_opt,
  output logic          gate_hi,
  output logic          gate_lo,
  output logic [PW-1:0] period,
  output logic [PW-1:0] step,
  output logic          locked,
  output logic          at_limit,
  output logic          update_done
);
  typedef enum logic {RUN, HOLD} state_t;
  localparam logic [PW-1:0] ONE  = PW'(1);
  localparam logic [PW-1:0] DT   = PW'(DEAD);
  localparam logic [PW:0]   PMIN = (PW+1)'(PERIOD_MIN);
  localparam logic [PW:0]   PMAX = (PW+1)'(PERIOD_MAX);
  state_t state, state_nx;
  logic [PW-1:0] cnt, half, step_use;
  logic [PW:0] cur, nxt;
  logic pending, pend_dir, last_dir, boundary, apply;
  always_ff @(posedge clk)
    if (!nrst) state <= RUN;
    else state <= state_nx;
  always_comb begin
    state_nx = freq_opt ? HOLD : RUN;
    half = period >> 1;
    boundary = cnt == period - ONE;
    apply = boundary && pending && state == RUN && !freq_opt;
    step_use = pend_dir != last_dir ? ((step >> 1) == '0 ? ONE : step >> 1) : step;
    cur = {1'b0, period};
    nxt = pend_dir ? (cur < PMIN + {1'b0, step_use} ? PMIN : cur - {1'b0, step_use})
                   : (cur + {1'b0, step_use} > PMAX ? PMAX : cur + {1'b0, step_use});
  end
  assign locked = state == HOLD;
  // new requests take priority over clearing, so a request on the boundary survives the apply
  always_ff @(posedge clk)
    if (!nrst) begin
      period      <= PW'(PERIOD_INIT);
      step        <= PW'(STEP_INIT);
      cnt         <= '0;
      pending     <= 1'b0;
      pend_dir    <= 1'b1;
      last_dir    <= 1'b1;
      gate_hi     <= 1'b0;
      gate_lo     <= 1'b0;
      at_limit    <= 1'b0;
      update_done <= 1'b0;
    end else begin
      cnt         <= boundary ? '0 : cnt + ONE;
      gate_hi     <= cnt >= DT && cnt < half;
      gate_lo     <= cnt >= half + DT && cnt < period;
      update_done <= apply;
      if (freq_opt) pending <= 1'b0;
      else if (freq_ready) begin
        pending  <= 1'b1;
        pend_dir <= freq_set_up_down;
      end else if (apply) pending <= 1'b0;
      if (apply) begin
        period   <= nxt[PW-1:0];
        step     <= step_use;
        last_dir <= pend_dir;
        at_limit <= nxt == PMIN || nxt == PMAX;
      end
    end
endmodule

// File: tb/tb_freq_stepper.sv
// tb_freq_stepper: directed checks of period stepping, clamping, request handling, lock and gate timing
module tb_freq_stepper;
  logic clk = 1'b0, nrst = 1'b0, freq_ready = 1'b0, freq_set_up_down = 1'b0, freq_opt = 1'b0;
  logic gate_hi, gate_lo, locked, at_limit, update_done;
  logic [15:0] period, step;
  int errors = 0, checks = 0, pos = 0, mper = 1250;
  always #5 clk = ~clk;
  freq_stepper dut (
    .clk(clk), .nrst(nrst), .freq_ready(freq_ready), .freq_set_up_down(freq_set_up_down),
    .freq_opt(freq_opt), .gate_hi(gate_hi), .gate_lo(gate_lo), .period(period), .step(step),
    .locked(locked), .at_limit(at_limit), .update_done(update_done)
  );
  task automatic tick();
    @(posedge clk);
    pos = (pos == mper - 1) ? 0 : pos + 1;
    #1;
  endtask
  task automatic req(input logic d);
    freq_ready = 1'b1;
    freq_set_up_down = d;
    tick();
    freq_ready = 1'b0;
  endtask
  task automatic run_to_wrap();
    do tick(); while (pos != 0);
  endtask
  task automatic test_reset();
    int ov = 0;
    nrst = 1'b0;
    repeat (3) tick();
    checks++; if (period !== 16'd1250) begin errors++; $display("FAIL reset_period got %0d want 1250", period); end
    checks++; if (step !== 16'd16) begin errors++; $display("FAIL reset_step got %0d want 16", step); end
    checks++; if ({gate_hi, gate_lo, update_done, locked, at_limit} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {gate_hi, gate_lo, update_done, locked, at_limit}); end
    nrst = 1'b1;
    pos = 0;
    mper = 1250;
    for (int i = 0; i < 1251; i++) begin
      tick();
      if (gate_hi && gate_lo) ov++;
      if (pos == 10) begin checks++; if (gate_hi !== 1'b0) begin errors++; $display("FAIL hi_before_dead got %b want 0", gate_hi); end end
      if (pos == 11) begin checks++; if (gate_hi !== 1'b1) begin errors++; $display("FAIL hi_rise got %b want 1", gate_hi); end end
      if (pos == 635) begin checks++; if (gate_lo !== 1'b0) begin errors++; $display("FAIL lo_before_dead got %b want 0", gate_lo); end end
      if (pos == 636) begin checks++; if (gate_lo !== 1'b1) begin errors++; $display("FAIL lo_rise got %b want 1", gate_lo); end end
    end
    checks++; if (ov != 0) begin errors++; $display("FAIL gate_overlap got %0d cycles want 0", ov); end
  endtask
  task automatic test_single_up();
    while (pos != 100) tick();
    req(1'b1);
    checks++; if (period !== 16'd1250) begin errors++; $display("FAIL up_early got %0d want 1250", period); end
    run_to_wrap();
    checks++; if (period !== 16'd1234) begin errors++; $display("FAIL up_period got %0d want 1234", period); end
    checks++; if (update_done !== 1'b1) begin errors++; $display("FAIL up_done got %b want 1", update_done); end
    mper = 1234;
    tick();
    checks++; if (update_done !== 1'b0) begin errors++; $display("FAIL up_done_pulse got %b want 0", update_done); end
    while (pos != 617) tick();
    checks++; if (gate_hi !== 1'b1) begin errors++; $display("FAIL hi_at_617 got %b want 1", gate_hi); end
    tick();
    checks++; if (gate_hi !== 1'b0) begin errors++; $display("FAIL hi_fall_618 got %b want 0", gate_hi); end
    while (pos != 627) tick();
    checks++; if (gate_lo !== 1'b0) begin errors++; $display("FAIL lo_at_627 got %b want 0", gate_lo); end
    tick();
    checks++; if (gate_lo !== 1'b1) begin errors++; $display("FAIL lo_rise_628 got %b want 1", gate_lo); end
    run_to_wrap();
  endtask
  task automatic test_reversal();
    logic d[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int es[5] = '{8, 4, 2, 1, 1};
    int ep[5] = '{1242, 1238, 1240, 1239, 1240};
    for (int i = 0; i < 5; i++) begin
      req(d[i]);
      run_to_wrap();
      checks++; if (step !== 16'(es[i]) || period !== 16'(ep[i])) begin errors++; $display("FAIL reversal_%0d got step %0d period %0d want step %0d period %0d", i, step, period, es[i], ep[i]); end
      mper = ep[i];
    end
  endtask
  task automatic test_clamp();
    while (pos != 300) tick();
    nrst = 1'b0;
    tick();
    checks++; if ({gate_hi, gate_lo} !== 2'b00 || period !== 16'd1250) begin errors++; $display("FAIL midreset got gates %b period %0d want 00 1250", {gate_hi, gate_lo}, period); end
    repeat (2) tick();
    nrst = 1'b1;
    pos = 0;
    mper = 1250;
    for (int i = 1; i <= 15; i++) begin
      req(1'b1);
      run_to_wrap();
      mper = 1250 - 16 * i;
    end
    checks++; if (period !== 16'd1010 || at_limit !== 1'b0) begin errors++; $display("FAIL clamp_pre got %0d lim %b want 1010 0", period, at_limit); end
    req(1'b1);
    run_to_wrap();
    checks++; if (period !== 16'd1000 || at_limit !== 1'b1) begin errors++; $display("FAIL clamp_min got %0d lim %b want 1000 1", period, at_limit); end
    mper = 1000;
    req(1'b1);
    run_to_wrap();
    checks++; if (period !== 16'd1000 || at_limit !== 1'b1 || step !== 16'd16) begin errors++; $display("FAIL clamp_hold got %0d lim %b step %0d want 1000 1 16", period, at_limit, step); end
    req(1'b0);
    run_to_wrap();
    checks++; if (period !== 16'd1008 || at_limit !== 1'b0 || step !== 16'd8) begin errors++; $display("FAIL clamp_release got %0d lim %b step %0d want 1008 0 8", period, at_limit, step); end
    mper = 1008;
  endtask
  task automatic test_overwrite();
    req(1'b1);
    repeat (5) tick();
    req(1'b0);
    run_to_wrap();
    checks++; if (period !== 16'd1016 || step !== 16'd8) begin errors++; $display("FAIL overwrite got %0d step %0d want 1016 8", period, step); end
    mper = 1016;
    while (pos != mper - 1) tick();
    req(1'b1);
    checks++; if (update_done !== 1'b0 || period !== 16'd1016) begin errors++; $display("FAIL coincide_now got done %b period %0d want 0 1016", update_done, period); end
    run_to_wrap();
    checks++; if (period !== 16'd1012 || step !== 16'd4 || update_done !== 1'b1) begin errors++; $display("FAIL coincide_next got %0d step %0d done %b want 1012 4 1", period, step, update_done); end
    mper = 1012;
  endtask
  task automatic test_lock();
    int nupd = 0;
    req(1'b1);
    freq_opt = 1'b1;
    tick();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_set got %b want 1", locked); end
    for (int i = 0; i < 3 * 1012 + 5; i++) begin
      freq_ready = (i % 400 == 7);
      freq_set_up_down = 1'b1;
      tick();
      freq_ready = 1'b0;
      if (update_done) nupd++;
    end
    checks++; if (nupd != 0 || period !== 16'd1012 || step !== 16'd4) begin errors++; $display("FAIL lock_hold got updates %0d period %0d step %0d want 0 1012 4", nupd, period, step); end
    freq_opt = 1'b0;
    repeat (2) tick();
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_clear got %b want 0", locked); end
    req(1'b1);
    run_to_wrap();
    checks++; if (period !== 16'd1008 || step !== 16'd4 || update_done !== 1'b1) begin errors++; $display("FAIL unlock_step got %0d step %0d done %b want 1008 4 1", period, step, update_done); end
  endtask
  initial begin
    test_reset();
    test_single_up();
    test_reversal();
    test_clamp();
    test_overwrite();
    test_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
